// File: rtl/motor_phase_decoder_pkg.sv
// Shared definitions for the stepper drive-pattern decoder.
// Holds the one-hot phase codes, the motion state encoding, the default
// step geometry and the step-length helper used for position bookkeeping.
package motor_phase_decoder_pkg;

    // One-hot drive codes, phase index 0..3, plus the all-off idle code
    localparam logic [3:0] PH0     = 4'b0001;
    localparam logic [3:0] PH1     = 4'b0010;
    localparam logic [3:0] PH2     = 4'b0100;
    localparam logic [3:0] PH3     = 4'b1000;
    localparam logic [3:0] PH_IDLE = 4'b0000;

    // Default step geometry: 24 short + 8 long positions = 200 steps/rev
    localparam int unsigned STEP_SHORT_DFLT = 6;
    localparam int unsigned STEP_LONG_DFLT  = 7;
    localparam int unsigned SUB_W           = 3;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } motion_e;

    // Steps needed to leave a position; every fourth position is long
    function automatic logic [SUB_W-1:0] steps(
        input logic [1:0]       p_lo,
        input logic [SUB_W-1:0] s_short,
        input logic [SUB_W-1:0] s_long
    );
        return (p_lo == 2'd3) ? s_long : s_short;
    endfunction

endpackage

// File: rtl/motor_phase_decoder_idx.sv
// Combinational phase-code classifier for the 4-bit stepper drive pattern.
// Ports:
//   motor_drv  observed drive pattern
//   valid      pattern is one of the four one-hot phase codes
//   idle       pattern is all-off
//   idx        phase index 0..3 (meaningful only when valid)
module motor_phase_idx
    import motor_phase_decoder_pkg::*;
(
    input  logic [3:0] motor_drv,
    output logic       valid,
    output logic       idle,
    output logic [1:0] idx
);

    // Anything that is neither one-hot nor all-off is illegal (valid=idle=0)
    always_comb begin
        valid = 1'b0;
        idle  = 1'b0;
        idx   = 2'd0;
        case (motor_drv)
            PH0:     begin valid = 1'b1; idx = 2'd0; end
            PH1:     begin valid = 1'b1; idx = 2'd1; end
            PH2:     begin valid = 1'b1; idx = 2'd2; end
            PH3:     begin valid = 1'b1; idx = 2'd3; end
            PH_IDLE: idle = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/motor_phase_decoder.sv
// Position monitor for a 4-phase stepper: decodes the one-hot drive pattern
// into forward/reverse steps, tracks dial position and sub-step offset,
// tracks motion state and flags sequence faults.
// Optional macro MTR_DEC_SYNC_EN inserts a 2-flop synchronizer on motor_drv
// (decode latency becomes 3 cycles instead of 1).
// Ports:
//   drv_clk, reset (async, active-high)
//   motor_drv  observed drive pattern;  clear_err  clears sticky errors
//   pos, substep, at_pos               dial location
//   step_fwd, step_rev, wrap           one-cycle event pulses
//   moving, dir                        motion state / last direction (1=rev)
//   err_skip, err_code                 sticky fault flags
module motor_phase_decoder
    import motor_phase_decoder_pkg::*;
#(
    parameter int unsigned POS_W      = 5,
    parameter int unsigned STEP_SHORT = STEP_SHORT_DFLT,
    parameter int unsigned STEP_LONG  = STEP_LONG_DFLT,
    parameter int unsigned IDLE_CYC   = 8
) (
    input  logic             drv_clk,
    input  logic             reset,
    input  logic [3:0]       motor_drv,
    input  logic             clear_err,
    output logic [POS_W-1:0] pos,
    output logic [2:0]       substep,
    output logic             at_pos,
    output logic             step_fwd,
    output logic             step_rev,
    output logic             wrap,
    output logic             moving,
    output logic             dir,
    output logic             err_skip,
    output logic             err_code
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);

    logic [3:0] drv;

`ifdef MTR_DEC_SYNC_EN
    // Two-flop synchronizer for pin-sourced or foreign-clock drive
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= PH_IDLE;
            sync_q2 <= PH_IDLE;
        end else begin
            sync_q1 <= motor_drv;
            sync_q2 <= sync_q1;
        end
    end

    assign drv = sync_q2;
`else
    assign drv = motor_drv;
`endif

    logic       code_valid;
    logic       code_idle;
    logic [1:0] code_idx;

    motor_phase_idx u_idx (
        .motor_drv (drv),
        .valid     (code_valid),
        .idle      (code_idle),
        .idx       (code_idx)
    );

    motion_e           state, state_nxt;
    logic [1:0]        last_idx, last_idx_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [POS_W-1:0]  pos_nxt, pos_dec;
    logic [2:0]        substep_nxt;
    logic              fwd_nxt, rev_nxt, wrap_nxt, dir_nxt;
    logic              err_skip_nxt, err_code_nxt;
    logic [1:0]        delta;
    logic [2:0]        len_cur, len_prev;

    assign delta    = code_idx - last_idx;
    assign pos_dec  = pos - POS_W'(1);
    assign len_cur  = steps(pos[1:0], SUB_W'(STEP_SHORT), SUB_W'(STEP_LONG));
    assign len_prev = steps(pos_dec[1:0], SUB_W'(STEP_SHORT), SUB_W'(STEP_LONG));

    // State register
    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) state <= STOP;
        else       state <= state_nxt;
    end

    // Next-state: step classification, position bookkeeping, motion FSM, errors
    always_comb begin
        state_nxt    = state;
        last_idx_nxt = last_idx;
        idle_cnt_nxt = idle_cnt;
        pos_nxt      = pos;
        substep_nxt  = substep;
        fwd_nxt      = 1'b0;
        rev_nxt      = 1'b0;
        wrap_nxt     = 1'b0;
        dir_nxt      = dir;
        err_skip_nxt = err_skip & ~clear_err;
        err_code_nxt = err_code & ~clear_err;

        if (code_valid) begin
            last_idx_nxt = code_idx;
            case (delta)
                2'd1:    fwd_nxt = 1'b1;
                2'd3:    rev_nxt = 1'b1;
                2'd2:    err_skip_nxt = 1'b1;
                default: ;
            endcase
        end else if (!code_idle) begin
            err_code_nxt = 1'b1;
        end

        if (fwd_nxt) begin
            if (substep + 3'd1 == len_cur) begin
                pos_nxt     = pos + POS_W'(1);
                substep_nxt = 3'd0;
                wrap_nxt    = (pos == {POS_W{1'b1}});
            end else begin
                substep_nxt = substep + 3'd1;
            end
        end else if (rev_nxt) begin
            if (substep == 3'd0) begin
                pos_nxt     = pos_dec;
                substep_nxt = len_prev - 3'd1;
                wrap_nxt    = (pos == '0);
            end else begin
                substep_nxt = substep - 3'd1;
            end
        end

        // Idle counter saturates at IDLE_CYC, where motion is declared stopped
        if (fwd_nxt || rev_nxt) begin
            idle_cnt_nxt = '0;
        end else if (idle_cnt != IDLE_W'(IDLE_CYC)) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end

        if (fwd_nxt) begin
            state_nxt = FWD;
            dir_nxt   = 1'b0;
        end else if (rev_nxt) begin
            state_nxt = REV;
            dir_nxt   = 1'b1;
        end else if (idle_cnt_nxt == IDLE_W'(IDLE_CYC)) begin
            state_nxt = STOP;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            last_idx <= 2'd0;
            idle_cnt <= '0;
            pos      <= '0;
            substep  <= 3'd0;
            at_pos   <= 1'b1;
            step_fwd <= 1'b0;
            step_rev <= 1'b0;
            wrap     <= 1'b0;
            moving   <= 1'b0;
            dir      <= 1'b0;
            err_skip <= 1'b0;
            err_code <= 1'b0;
        end else begin
            last_idx <= last_idx_nxt;
            idle_cnt <= idle_cnt_nxt;
            pos      <= pos_nxt;
            substep  <= substep_nxt;
            at_pos   <= (substep_nxt == 3'd0);
            step_fwd <= fwd_nxt;
            step_rev <= rev_nxt;
            wrap     <= wrap_nxt;
            moving   <= (state_nxt != STOP);
            dir      <= dir_nxt;
            err_skip <= err_skip_nxt;
            err_code <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_motor_phase_decoder.sv
// Directed self-checking bench for motor_phase_decoder (default build).
module tb_motor_phase_decoder;

    logic       drv_clk = 1'b0;
    logic       reset;
    logic [3:0] motor_drv;
    logic       clear_err;
    logic [4:0] pos;
    logic [2:0] substep;
    logic       at_pos, step_fwd, step_rev, wrap, moving, dir, err_skip, err_code;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] cur = 2'd0;

    motor_phase_decoder dut (
        .drv_clk   (drv_clk),
        .reset     (reset),
        .motor_drv (motor_drv),
        .clear_err (clear_err),
        .pos       (pos),
        .substep   (substep),
        .at_pos    (at_pos),
        .step_fwd  (step_fwd),
        .step_rev  (step_rev),
        .wrap      (wrap),
        .moving    (moving),
        .dir       (dir),
        .err_skip  (err_skip),
        .err_code  (err_code)
    );

    always #5 drv_clk = ~drv_clk;

    task automatic do_reset();
        reset     = 1'b1;
        motor_drv = 4'b0000;
        clear_err = 1'b0;
        cur       = 2'd0;
        repeat (2) @(posedge drv_clk);
        @(negedge drv_clk);
        reset = 1'b0;
    endtask

    // Drive a code for one cycle and sample just after the sampling edge
    task automatic apply(input logic [3:0] code);
        @(negedge drv_clk);
        motor_drv = code;
        @(posedge drv_clk);
        #1;
    endtask

    task automatic fwd_step();
        logic [3:0] one;
        one = 4'b0001;
        cur = cur + 2'd1;
        apply(4'(one << cur));
    endtask

    task automatic rev_step();
        logic [3:0] one;
        one = 4'b0001;
        cur = cur - 2'd1;
        apply(4'(one << cur));
    endtask

    task automatic test_reset();
        reset = 1'b1; motor_drv = 4'b0000; clear_err = 1'b0;
        repeat (2) @(posedge drv_clk);
        #1;
        tests++;
        if ({pos, substep, at_pos, moving, dir} !== {5'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_pos: got pos=%0d sub=%0d at_pos=%b moving=%b dir=%b, want 0 0 1 0 0",
                     pos, substep, at_pos, moving, dir);
        end
        tests++;
        if ({step_fwd, step_rev, wrap, err_skip, err_code} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_flags: got fwd,rev,wrap,skip,code=%b, want 00000",
                     {step_fwd, step_rev, wrap, err_skip, err_code});
        end
        @(negedge drv_clk);
        reset = 1'b0;
        cur = 2'd0;
    endtask

    task automatic test_forward6();
        int pulses;
        do_reset();
        pulses = 0;
        fwd_step();
        pulses += int'(step_fwd);
        tests++;
        if ({substep, at_pos, step_fwd} !== {3'd1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL fwd_first: got sub=%0d at_pos=%b fwd=%b, want 1 0 1", substep, at_pos, step_fwd);
        end
        for (int i = 0; i < 5; i++) begin
            fwd_step();
            pulses += int'(step_fwd);
        end
        tests++;
        if (pulses !== 6) begin
            fails++;
            $display("FAIL fwd6_pulses: got %0d, want 6", pulses);
        end
        tests++;
        if ({pos, substep, at_pos, dir, moving} !== {5'd1, 3'd0, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL fwd6_state: got pos=%0d sub=%0d at_pos=%b dir=%b moving=%b, want 1 0 1 0 1",
                     pos, substep, at_pos, dir, moving);
        end
    endtask

    task automatic test_long_leg();
        do_reset();
        for (int i = 0; i < 24; i++) fwd_step();
        tests++;
        if ({pos, substep} !== {5'd3, 3'd6}) begin
            fails++;
            $display("FAIL long_24: got pos=%0d sub=%0d, want 3 6", pos, substep);
        end
        fwd_step();
        tests++;
        if ({pos, substep} !== {5'd4, 3'd0}) begin
            fails++;
            $display("FAIL long_25: got pos=%0d sub=%0d, want 4 0", pos, substep);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        rev_step();
        tests++;
        if ({step_rev, step_fwd, wrap, pos, substep, dir} !== {1'b1, 1'b0, 1'b1, 5'd31, 3'd6, 1'b1}) begin
            fails++;
            $display("FAIL rev_wrap: got rev=%b fwd=%b wrap=%b pos=%0d sub=%0d dir=%b, want 1 0 1 31 6 1",
                     step_rev, step_fwd, wrap, pos, substep, dir);
        end
        rev_step();
        tests++;
        if ({step_rev, wrap, substep} !== {1'b1, 1'b0, 3'd5}) begin
            fails++;
            $display("FAIL rev_second: got rev=%b wrap=%b sub=%0d, want 1 0 5", step_rev, wrap, substep);
        end
        for (int i = 0; i < 5; i++) rev_step();
        tests++;
        if ({pos, substep, at_pos} !== {5'd31, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL rev_7: got pos=%0d sub=%0d at_pos=%b, want 31 0 1", pos, substep, at_pos);
        end
        rev_step();
        tests++;
        if ({pos, substep, wrap} !== {5'd30, 3'd5, 1'b0}) begin
            fails++;
            $display("FAIL rev_short: got pos=%0d sub=%0d wrap=%b, want 30 5 0", pos, substep, wrap);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        fwd_step();
        rev_step();
        tests++;
        if ({step_rev, wrap, pos, substep, dir, moving} !== {1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reversal_rev: got rev=%b wrap=%b pos=%0d sub=%0d dir=%b moving=%b, want 1 0 0 0 1 1",
                     step_rev, wrap, pos, substep, dir, moving);
        end
        fwd_step();
        tests++;
        if ({step_fwd, dir, substep} !== {1'b1, 1'b0, 3'd1}) begin
            fails++;
            $display("FAIL reversal_fwd: got fwd=%b dir=%b sub=%0d, want 1 0 1", step_fwd, dir, substep);
        end
    endtask

    task automatic test_errors();
        do_reset();
        apply(4'b0100);
        cur = 2'd2;
        tests++;
        if ({err_skip, pos, substep, step_fwd, step_rev} !== {1'b1, 5'd0, 3'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL skip_detect: got skip=%b pos=%0d sub=%0d fwd=%b rev=%b, want 1 0 0 0 0",
                     err_skip, pos, substep, step_fwd, step_rev);
        end
        fwd_step();
        tests++;
        if ({step_fwd, substep, err_skip} !== {1'b1, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL skip_then_step: got fwd=%b sub=%0d skip=%b, want 1 1 1", step_fwd, substep, err_skip);
        end
        apply(4'b0011);
        tests++;
        if ({err_code, substep, step_fwd, step_rev} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL code_detect: got code=%b sub=%0d fwd=%b rev=%b, want 1 1 0 0",
                     err_code, substep, step_fwd, step_rev);
        end
        @(negedge drv_clk);
        clear_err = 1'b1;
        apply(4'b0011);
        tests++;
        if ({err_code, err_skip} !== 2'b10) begin
            fails++;
            $display("FAIL clear_vs_new: got code=%b skip=%b, want 1 0", err_code, err_skip);
        end
        apply(4'b0000);
        @(negedge drv_clk);
        clear_err = 1'b0;
        tests++;
        if (err_code !== 1'b0) begin
            fails++;
            $display("FAIL clear_alone: got code=%b, want 0", err_code);
        end
        // last_idx must still be 3 after the illegal codes
        fwd_step();
        tests++;
        if ({step_fwd, substep} !== {1'b1, 3'd2}) begin
            fails++;
            $display("FAIL idx_held: got fwd=%b sub=%0d, want 1 2", step_fwd, substep);
        end
    endtask

    task automatic test_idle_and_rev();
        int wraps;
        int wrap_at;
        int pulses;
        do_reset();
        fwd_step();
        for (int i = 0; i < 7; i++) apply(4'b0000);
        tests++;
        if (moving !== 1'b1) begin
            fails++;
            $display("FAIL idle_7: got moving=%b, want 1", moving);
        end
        apply(4'b0000);
        tests++;
        if (moving !== 1'b0) begin
            fails++;
            $display("FAIL idle_8: got moving=%b, want 0", moving);
        end
        do_reset();
        wraps = 0; wrap_at = -1; pulses = 0;
        for (int i = 1; i <= 200; i++) begin
            fwd_step();
            pulses += int'(step_fwd);
            if (wrap) begin
                wraps++;
                wrap_at = i;
            end
        end
        tests++;
        if ({wraps, wrap_at, pulses} !== {32'sd1, 32'sd200, 32'sd200}) begin
            fails++;
            $display("FAIL rev200_wrap: got wraps=%0d at=%0d pulses=%0d, want 1 200 200", wraps, wrap_at, pulses);
        end
        tests++;
        if ({pos, substep, at_pos} !== {5'd0, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL rev200_pos: got pos=%0d sub=%0d at_pos=%b, want 0 0 1", pos, substep, at_pos);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) fwd_step();
        apply(4'b0011);
        @(negedge drv_clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({pos, substep, moving, err_code, step_fwd} !== {5'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: got pos=%0d sub=%0d moving=%b code=%b fwd=%b, want 0 0 0 0 0",
                     pos, substep, moving, err_code, step_fwd);
        end
        @(negedge drv_clk);
        motor_drv = 4'b0000;
        reset = 1'b0;
        cur = 2'd0;
    endtask

    initial begin
        test_reset();
        test_forward6();
        test_long_leg();
        test_reverse();
        test_reversal();
        test_errors();
        test_idle_and_rev();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
